// File: rtl/bin2bcd_if.sv
// Request/result bundle for bin2bcd_seq: the master drives start/bin, the slave returns
// ready, valid, bcd and overflow.
interface bin2bcd_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  ready;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  ready, valid, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output ready, valid, bcd, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Define BIN2BCD_SATURATE_EN to clamp out-of-range results to all nines and flag overflow.
//
// state | meaning
// IDLE  | waiting for start, ready high
// SHIFT | add-3/shift one operand bit per cycle, ready low
// DONE  | result registered, valid high for this cycle, ready high
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic     clk,
  input  logic     rst,
  bin2bcd_if.slave bus
);
  localparam int SD = (BIN_W + 2) / 3;
  localparam int SW = 4 * SD;
  localparam int BW = 4 * DIGITS;
  localparam int EW = (SD > DIGITS) ? SW : BW;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [SW-1:0]    scratch_q;
  logic [SW-1:0]    scratch_d;
  logic [SW-1:0]    adj;
  logic [BIN_W-1:0] op_q;
  logic [BIN_W-1:0] op_d;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic             ovf_q;
  logic             ovf_d;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_d;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < SD; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    scratch_d = {adj[SW-2:0], op_q[BIN_W-1]};
    op_d      = {op_q[BIN_W-2:0], 1'b0};
    // Widen to whichever is larger so both truncation and zero-extension fall out of one cast.
    bcd_d     = BW'(EW'(scratch_d));
`ifdef BIN2BCD_SATURATE_EN
    ovf_d = (EW'(scratch_d) >> BW) != '0;
    if (ovf_d) bcd_d = {DIGITS{4'h9}};
`else
    ovf_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            op_q      <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CW'(BIN_W);
            state_q   <= SHIFT;
            ready_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          op_q      <= op_d;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.valid    = valid_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: table vectors, random operands against an arithmetic model,
// and hand-written sequences for ignore-start, reset abort and back-to-back streaming.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(14), .DIGITS(4)) if0 ();
  bin2bcd_if #(.BIN_W(20), .DIGITS(7)) if1 ();

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bin2bcd_seq #(.BIN_W(20), .DIGITS(7)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] last_bcd = '0;

  typedef struct {
    logic [13:0] b;
    logic [15:0] mod_bcd;
    logic [15:0] sat_bcd;
    logic        sat_ovf;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint pow10(int d);
    longint p = 1;
    for (int k = 0; k < d; k++) p *= 10;
    return p;
  endfunction

  function automatic logic [63:0] ref_bcd(longint v, int d);
    logic [63:0] r = '0;
    longint m;
`ifdef BIN2BCD_SATURATE_EN
    if (v >= pow10(d)) begin
      for (int k = 0; k < d; k++) r[4*k +: 4] = 4'h9;
      return r;
    end
`endif
    m = v % pow10(d);
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(longint v, int d);
`ifdef BIN2BCD_SATURATE_EN
    return v >= pow10(d);
`else
    return (v < 0) && (d < 0);
`endif
  endfunction

  task automatic conv0(string nm, logic [13:0] b, logic [15:0] eb, logic eo);
    int lat = 0;
    int rl  = 0;
    if0.start = 1'b1;
    if0.bin   = b;
    @(posedge clk); #1;
    if0.start = 1'b0;
    if0.bin   = ~b;
    chk({nm, "_hold"}, if0.bcd, last_bcd);
    while (!if0.valid && lat < 40) begin
      lat++;
      if (!if0.ready) rl++;
      @(posedge clk); #1;
    end
    chk({nm, "_lat"}, lat, 14);
    chk({nm, "_rdylow"}, rl, 14);
    chk({nm, "_bcd"}, if0.bcd, eb);
    chk({nm, "_ovf"}, if0.overflow, eo);
    last_bcd = eb;
    @(posedge clk); #1;
    chk({nm, "_pulse"}, if0.valid, 0);
  endtask

  task automatic conv1(string nm, logic [19:0] b, logic [27:0] eb);
    int lat = 0;
    if1.start = 1'b1;
    if1.bin   = b;
    @(posedge clk); #1;
    if1.start = 1'b0;
    while (!if1.valid && lat < 60) begin
      lat++;
      @(posedge clk); #1;
    end
    chk({nm, "_lat"}, lat, 20);
    chk({nm, "_bcd"}, if1.bcd, eb);
    chk({nm, "_ovf"}, if1.overflow, 0);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, if1.valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] b;
    logic [19:0] b1;
    logic [15:0] eb;
    logic        eo;
    int          nv;
    int          vidx;
    logic [15:0] vbcd;
    logic        vovf;

    tbl[0] = '{14'd0,     16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
    tbl[2] = '{14'd16383, 16'h6383, 16'h9999, 1'b1};
    tbl[3] = '{14'd10000, 16'h0000, 16'h9999, 1'b1};
    tbl[4] = '{14'd1,     16'h0001, 16'h0001, 1'b0};
    tbl[5] = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
    tbl[6] = '{14'd12345, 16'h2345, 16'h9999, 1'b1};
    tbl[7] = '{14'd5000,  16'h5000, 16'h5000, 1'b0};

    if0.start = 1'b0; if0.bin = '0;
    if1.start = 1'b0; if1.bin = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", if0.ready, 1);
    chk("rst_valid", if0.valid, 0);
    chk("rst_bcd", if0.bcd, 0);
    chk("rst_ovf", if0.overflow, 0);
    rst = 1'b1;

    // start presented immediately so the first edge after reset release must accept it
    conv0("first", 14'd77, 16'h0077, 1'b0);

    for (int i = 0; i < 8; i++) begin
`ifdef BIN2BCD_SATURATE_EN
      eb = tbl[i].sat_bcd; eo = tbl[i].sat_ovf;
`else
      eb = tbl[i].mod_bcd; eo = 1'b0;
`endif
      conv0($sformatf("tbl%0d", i), tbl[i].b, eb, eo);
    end

    for (int i = 0; i < 25; i++) begin
      b = 14'($urandom_range(0, 16383));
      conv0($sformatf("rnd%0d_%0d", i, b), b, 16'(ref_bcd(longint'(b), 4)), ref_ovf(longint'(b), 4));
    end

    conv1("w20_max", 20'd1048575, 28'h1048575);
    for (int i = 0; i < 4; i++) begin
      b1 = 20'($urandom_range(0, 1048575));
      conv1($sformatf("w20_rnd%0d", i), b1, 28'(ref_bcd(longint'(b1), 7)));
    end

    // second start mid-conversion must be ignored
    nv = 0; vidx = 0; vbcd = '0; vovf = 1'b0;
    if0.start = 1'b1; if0.bin = 14'd42;
    @(posedge clk); #1;
    if0.start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin if0.start = 1'b1; if0.bin = 14'd1234; end
      if (i == 8) if0.start = 1'b0;
      if (if0.valid) begin nv++; vidx = i; vbcd = if0.bcd; vovf = if0.overflow; end
      @(posedge clk); #1;
    end
    chk("ign_nvalid", nv, 1);
    chk("ign_at", vidx, 15);
    chk("ign_bcd", vbcd, 16'h0042);
    chk("ign_ovf", vovf, 0);
    last_bcd = 16'h0042;

    // reset in the middle of a conversion
    if0.start = 1'b1; if0.bin = 14'd777;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("abort_ready", if0.ready, 1);
    chk("abort_valid", if0.valid, 0);
    chk("abort_bcd", if0.bcd, 0);
    chk("abort_ovf", if0.overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    last_bcd = '0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (if0.valid) nv++;
      @(posedge clk); #1;
    end
    chk("abort_novalid", nv, 0);
    conv0("after_abort", 14'd500, 16'h0500, 1'b0);

    // start held high, one new operand per accept
    begin
      localparam int NOPS = 200;
      logic [13:0] q[$];
      int nacc = 0;
      int nval = 0;
      int lastv = -1;
      int nbadgap = 0;
      logic [13:0] ob;
      for (int cyc = 0; cyc < NOPS * 15 + 60; cyc++) begin
        if (if0.valid) begin
          if (q.size() == 0) begin
            chk("b2b_extra", 1, 0);
          end else begin
            ob = q.pop_front();
            chk($sformatf("b2b_bcd_%0d", ob), if0.bcd, 16'(ref_bcd(longint'(ob), 4)));
            chk($sformatf("b2b_ovf_%0d", ob), if0.overflow, ref_ovf(longint'(ob), 4));
          end
          nval++;
          if (lastv >= 0 && cyc - lastv != 15) nbadgap++;
          lastv = cyc;
        end
        if (if0.ready) begin
          if (nacc < NOPS) begin
            ob = (nacc == NOPS - 1) ? 14'h3FFF : 14'((nacc * 83) % 16384);
            if0.bin   = ob;
            if0.start = 1'b1;
            q.push_back(ob);
            nacc++;
          end else begin
            if0.start = 1'b0;
          end
        end
        if (nacc == NOPS && q.size() == 0) break;
        @(posedge clk); #1;
      end
      if0.start = 1'b0;
      chk("b2b_count", nval, NOPS);
      chk("b2b_gap", nbadgap, 0);
      repeat (20) begin
        @(posedge clk); #1;
        if (if0.valid) nval++;
      end
      chk("b2b_tail", nval, NOPS);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
